apb2axi_rsp_slicer: RTL and testbench
=====================================

# apb2axi_rsp_slicer

Parametrised per-tag read-response buffer and width slicer for the APB-to-AXI bridge response path. It accepts AXI read beats tagged by outstanding-transaction ID, queues them in independent per-tag FIFOs, and drains them as APB-width words on explicit per-tag requests from the register front end. Compared with the single-width handler, it adds a generic AXI/APB width ratio, proper output backpressure with a request-ready, empty-request miss reporting, per-word and sticky per-tag error status, and a per-tag flush.

## Interface
- TAG_NUM, 8: number of tags/FIFOs; power of two, ≥2.
- DEPTH, 8: beats per tag FIFO; power of two, ≥2.
- AXI_DATA_W, 64: AXI beat width.
- APB_DATA_W, 32: drain word width; RATIO=AXI_DATA_W/APB_DATA_W is a power of two, ≥1.
- TAG_W, $clog2(TAG_NUM): tag width (derived).

- pclk  in  1  single clock, rising edge.
- preset  in  1  asynchronous, active-high reset.
- in_vld  in  1  AXI beat valid.
- in_rdy  out  1  beat accepted when in_vld&&in_rdy.
- in_tag  in  TAG_W  beat tag.
- in_data  in  AXI_DATA_W  beat data.
- in_resp  in  2  AXI RRESP.
- in_last  in  1  RLAST.
- drn_req  in  1  request next word of drn_tag.
- drn_tag  in  TAG_W  tag to drain.
- drn_req_rdy  out  1  request accepted when drn_req&&drn_req_rdy.
- drn_vld  out  1  drain word valid.
- drn_rdy  in  1  consumer takes word when drn_vld&&drn_rdy.
- drn_data  out  APB_DATA_W  drain word.
- drn_last  out  1  final word of a beat marked last.
- drn_err  out  2  RRESP of the beat the word came from.
- drn_miss  out  1  one-cycle pulse: accepted request found tag empty.
- flush_vld  in  1  flush flush_tag.
- flush_tag  in  TAG_W  tag to flush.
- tag_avail  out  TAG_NUM  bit t: tag t has a word available (slice pending or count>0).
- tag_err  out  TAG_NUM  bit t: sticky, some accepted beat on t had in_resp[1]=1.

## Operation
- Per tag: circular FIFO (head, tail, count 0..DEPTH), slice register (cur_data, cur_resp, cur_last, cur_idx 0..RATIO-1, cur_valid).
- in_rdy = (count[in_tag] < DEPTH) && !(flush_vld && flush_tag==in_tag). Accepted beat written at tail, tail+1 mod DEPTH, count+1; if in_resp[1] set tag_err[in_tag].
- drn_req_rdy = !drn_vld || drn_rdy.
- Accepted request on tag t:
  - cur_valid[t]: output cur_data word cur_idx (bits [cur_idx*APB_DATA_W +: APB_DATA_W]), cur_idx+1; on index RATIO-1 clear cur_valid, drn_last=cur_last.
  - else count[t]>0: pop head beat; output word 0; if RATIO>1 load slice register with cur_idx=1, else drn_last=beat last.
  - else: drn_vld stays/goes 0, drn_miss=1 next cycle.
- drn_err = resp of the source beat for every word of that beat.
- Words leave in little-endian order (word 0 = LSBs).
- Flush of tag t: head=tail=count=0, cur_valid=0, tag_err[t]=0. A word already in the drain output register is unaffected.
- Memory contents not reset; only pointers/state.

## Timing
- Reset (async assert): all heads/tails/counts/cur_idx 0, cur_valid 0, drn_vld 0, drn_data 0, drn_last 0, drn_err 0, drn_miss 0, tag_err 0. Outputs in_rdy, drn_req_rdy, tag_avail are combinational from reset state (in_rdy=1, drn_req_rdy=1, tag_avail=0).
- Request accepted at edge N → drn_vld/drn_data/drn_last/drn_err valid after edge N, held until drn_rdy. Back-to-back one word per cycle when drn_rdy=1.
- Beat accepted at edge N → drainable by a request at edge N+1 (no bypass).
- Enqueue and pop on same tag same cycle: both happen, count unchanged; full FIFO with a same-cycle pop still reports in_rdy=0.
- Flush and request on same tag same cycle: flush wins, request reports drn_miss.
- Flush and enqueue on same tag: in_rdy=0, beat not taken.
- Pointer wrap modulo DEPTH; count never exceeds DEPTH or underflows.
- Reset mid-drain: drn_vld drops immediately, all queued beats discarded.

## Test plan
- RATIO=2: enqueue tag 3 beats 0x1111_2222_3333_4444 (last=0), 0x5555_6666_7777_8888 (last=1); four requests → 0x33334444, 0x11112222, 0x77778888, 0x55556666; drn_last only on fourth.
- Fill tag 0 with 8 beats → in_rdy=0 for tag 0, in_rdy=1 for tag 1; one beat drained (2 words) → in_rdy=1; wrap enqueue of 9th beat drains correctly.
- Request on empty tag 5 → drn_miss=1 one cycle, drn_vld=0.
- Beat tag 2 with in_resp=2'b10 → tag_err[2]=1, drn_err=2'b10 on both words; flush tag 2 → tag_err[2]=0, tag_avail[2]=0.
- Hold drn_rdy=0 with drn_vld=1 → drn_req_rdy=0, data stable; release → next request proceeds.
- Assert preset mid-slice (cur_idx=1) → drn_vld=0 asynchronously, tag_avail all 0 after release.

Source files
------------

// File: rtl/apb2axi_rsp_slicer.sv
// Per-tag read-response buffer: queues tagged AXI beats and drains each one as APB-width words on request.
// Latency: a request accepted at edge N presents its word after edge N. A beat accepted at edge N can be drained from edge N+1.
// Backpressure: in_rdy drops when the tag FIFO is full or that tag is being flushed. drn_req_rdy drops while an unconsumed word is held.
//
// Ports:
//   pclk, preset                 clock, asynchronous active-high reset
//   in_vld/in_rdy/in_tag/...     AXI read beat input (data, resp, last)
//   drn_req/drn_req_rdy/drn_tag  per-tag word request from the register front end
//   drn_vld/drn_rdy/drn_data/... registered drain word (last, err, miss pulse)
//   flush_vld/flush_tag          discard everything queued on one tag
//   tag_avail/tag_err            per-tag word-available and sticky slave-error status
module apb2axi_rsp_slicer #(
    parameter int TAG_NUM    = 8,
    parameter int DEPTH      = 8,
    parameter int AXI_DATA_W = 64,
    parameter int APB_DATA_W = 32,
    parameter int TAG_W      = $clog2(TAG_NUM)
) (
    input  logic                  pclk,
    input  logic                  preset,
    // AXI beat input
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [AXI_DATA_W-1:0] in_data,
    input  logic [1:0]            in_resp,
    input  logic                  in_last,
    // drain request
    input  logic                  drn_req,
    input  logic [TAG_W-1:0]      drn_tag,
    output logic                  drn_req_rdy,
    // drain word output
    output logic                  drn_vld,
    input  logic                  drn_rdy,
    output logic [APB_DATA_W-1:0] drn_data,
    output logic                  drn_last,
    output logic [1:0]            drn_err,
    output logic                  drn_miss,
    // flush
    input  logic                  flush_vld,
    input  logic [TAG_W-1:0]      flush_tag,
    // status
    output logic [TAG_NUM-1:0]    tag_avail,
    output logic [TAG_NUM-1:0]    tag_err
);

    localparam int RATIO = AXI_DATA_W / APB_DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef struct packed {
        logic                  last;
        logic [1:0]            resp;
        logic [AXI_DATA_W-1:0] data;
    } beat_t;

    // Beat storage: not reset, only the pointers qualify its contents.
    beat_t mem_q [TAG_NUM][DEPTH];

    // Per-tag FIFO pointers
    logic [PTR_W-1:0]      head_q      [TAG_NUM];
    logic [PTR_W-1:0]      head_d      [TAG_NUM];
    logic [PTR_W-1:0]      tail_q      [TAG_NUM];
    logic [PTR_W-1:0]      tail_d      [TAG_NUM];
    logic [CNT_W-1:0]      cnt_q       [TAG_NUM];
    logic [CNT_W-1:0]      cnt_d       [TAG_NUM];

    // Per-tag slice register: the beat currently being handed out word by word
    logic [AXI_DATA_W-1:0] cur_data_q  [TAG_NUM];
    logic [AXI_DATA_W-1:0] cur_data_d  [TAG_NUM];
    logic [1:0]            cur_resp_q  [TAG_NUM];
    logic [1:0]            cur_resp_d  [TAG_NUM];
    logic                  cur_last_q  [TAG_NUM];
    logic                  cur_last_d  [TAG_NUM];
    logic [IDX_W-1:0]      cur_idx_q   [TAG_NUM];
    logic [IDX_W-1:0]      cur_idx_d   [TAG_NUM];
    logic [TAG_NUM-1:0]    cur_valid_q;
    logic [TAG_NUM-1:0]    cur_valid_d;

    logic [TAG_NUM-1:0]    tag_err_q;
    logic [TAG_NUM-1:0]    tag_err_d;

    // Drain output register
    logic                  drn_vld_q;
    logic                  drn_vld_d;
    logic [APB_DATA_W-1:0] drn_data_q;
    logic [APB_DATA_W-1:0] drn_data_d;
    logic                  drn_last_q;
    logic                  drn_last_d;
    logic [1:0]            drn_err_q;
    logic [1:0]            drn_err_d;
    logic                  drn_miss_q;
    logic                  drn_miss_d;

    // Per-cycle decode
    logic                  in_acc;
    logic                  req_acc;
    logic                  req_flush;
    logic                  do_slice;
    logic                  do_pop;
    logic [TAG_NUM-1:0]    enq_oh;
    logic [TAG_NUM-1:0]    pop_oh;
    beat_t                 pop_beat;

    // ------------------------------------------------------------------
    // Handshakes and status
    // ------------------------------------------------------------------
    // A beat aimed at a tag that is being flushed this cycle is refused
    // rather than written, so the flush never has to race a write.
    assign in_rdy      = (cnt_q[in_tag] < CNT_W'(DEPTH)) &&
                         !(flush_vld && (flush_tag == in_tag));
    assign drn_req_rdy = !drn_vld_q || drn_rdy;

    always_comb begin
        for (int t = 0; t < TAG_NUM; t++) begin
            tag_avail[t] = cur_valid_q[t] || (cnt_q[t] != '0);
        end
    end

    assign tag_err  = tag_err_q;
    assign drn_vld  = drn_vld_q;
    assign drn_data = drn_data_q;
    assign drn_last = drn_last_q;
    assign drn_err  = drn_err_q;
    assign drn_miss = drn_miss_q;

    // ------------------------------------------------------------------
    // Request decode: a pending slice always drains before the FIFO head,
    // so words of one beat are never interleaved with the next beat.
    // ------------------------------------------------------------------
    always_comb begin
        in_acc    = in_vld && in_rdy;
        req_acc   = drn_req && drn_req_rdy;
        req_flush = flush_vld && (flush_tag == drn_tag);
        do_slice  = 1'b0;
        do_pop    = 1'b0;
        if (req_acc && !req_flush) begin
            if (cur_valid_q[drn_tag]) begin
                do_slice = 1'b1;
            end else if (cnt_q[drn_tag] != '0) begin
                do_pop = 1'b1;
            end
        end
        enq_oh   = in_acc ? (TAG_NUM'(1) << in_tag)  : '0;
        pop_oh   = do_pop ? (TAG_NUM'(1) << drn_tag) : '0;
        pop_beat = mem_q[drn_tag][head_q[drn_tag]];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        cur_data_d  = cur_data_q;
        cur_resp_d  = cur_resp_q;
        cur_last_d  = cur_last_q;
        cur_idx_d   = cur_idx_q;
        cur_valid_d = cur_valid_q;
        tag_err_d   = tag_err_q;
        drn_vld_d   = drn_vld_q;
        drn_data_d  = drn_data_q;
        drn_last_d  = drn_last_q;
        drn_err_d   = drn_err_q;
        drn_miss_d  = 1'b0;

        // Consumer took the held word.
        if (drn_vld_q && drn_rdy) begin
            drn_vld_d = 1'b0;
        end

        if (req_acc) begin
            if (do_slice) begin
                drn_vld_d  = 1'b1;
                drn_data_d = cur_data_q[drn_tag][cur_idx_q[drn_tag]*APB_DATA_W +: APB_DATA_W];
                drn_err_d  = cur_resp_q[drn_tag];
                drn_last_d = 1'b0;
                if (cur_idx_q[drn_tag] == IDX_W'(RATIO - 1)) begin
                    cur_valid_d[drn_tag] = 1'b0;
                    cur_idx_d[drn_tag]   = '0;
                    drn_last_d           = cur_last_q[drn_tag];
                end else begin
                    cur_idx_d[drn_tag] = cur_idx_q[drn_tag] + IDX_W'(1);
                end
            end else if (do_pop) begin
                drn_vld_d       = 1'b1;
                drn_data_d      = pop_beat.data[APB_DATA_W-1:0];
                drn_err_d       = pop_beat.resp;
                head_d[drn_tag] = head_q[drn_tag] + PTR_W'(1);
                if (RATIO > 1) begin
                    // Word 0 leaves now; the rest of the beat parks in the slice.
                    cur_data_d[drn_tag]  = pop_beat.data;
                    cur_resp_d[drn_tag]  = pop_beat.resp;
                    cur_last_d[drn_tag]  = pop_beat.last;
                    cur_idx_d[drn_tag]   = IDX_W'(1);
                    cur_valid_d[drn_tag] = 1'b1;
                    drn_last_d           = 1'b0;
                end else begin
                    drn_last_d = pop_beat.last;
                end
            end else begin
                // Empty tag, or the tag is being flushed under the request.
                drn_miss_d = 1'b1;
            end
        end

        if (in_acc) begin
            tail_d[in_tag] = tail_q[in_tag] + PTR_W'(1);
            if (in_resp[1]) begin
                tag_err_d[in_tag] = 1'b1;
            end
        end

        // Simultaneous push and pop on one tag leave the count unchanged.
        for (int t = 0; t < TAG_NUM; t++) begin
            if (enq_oh[t] && !pop_oh[t]) begin
                cnt_d[t] = cnt_q[t] + CNT_W'(1);
            end else if (!enq_oh[t] && pop_oh[t]) begin
                cnt_d[t] = cnt_q[t] - CNT_W'(1);
            end
        end

        // Flush overrides everything else on its tag; the output register
        // keeps any word it already holds.
        if (flush_vld) begin
            head_d[flush_tag]      = '0;
            tail_d[flush_tag]      = '0;
            cnt_d[flush_tag]       = '0;
            cur_valid_d[flush_tag] = 1'b0;
            cur_idx_d[flush_tag]   = '0;
            tag_err_d[flush_tag]   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int t = 0; t < TAG_NUM; t++) begin
                head_q[t]     <= '0;
                tail_q[t]     <= '0;
                cnt_q[t]      <= '0;
                cur_data_q[t] <= '0;
                cur_resp_q[t] <= '0;
                cur_last_q[t] <= 1'b0;
                cur_idx_q[t]  <= '0;
            end
            cur_valid_q <= '0;
            tag_err_q   <= '0;
            drn_vld_q   <= 1'b0;
            drn_data_q  <= '0;
            drn_last_q  <= 1'b0;
            drn_err_q   <= '0;
            drn_miss_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            cur_data_q  <= cur_data_d;
            cur_resp_q  <= cur_resp_d;
            cur_last_q  <= cur_last_d;
            cur_idx_q   <= cur_idx_d;
            cur_valid_q <= cur_valid_d;
            tag_err_q   <= tag_err_d;
            drn_vld_q   <= drn_vld_d;
            drn_data_q  <= drn_data_d;
            drn_last_q  <= drn_last_d;
            drn_err_q   <= drn_err_d;
            drn_miss_q  <= drn_miss_d;
        end
    end

    // Beat memory write port
    always_ff @(posedge pclk) begin
        if (in_acc) begin
            mem_q[in_tag][tail_q[in_tag]] <= '{last: in_last, resp: in_resp, data: in_data};
        end
    end

endmodule

// File: tb/tb_apb2axi_rsp_slicer.sv
// Bench for apb2axi_rsp_slicer: directed scenarios plus randomized traffic against a word-queue model.
// Latency: inputs are driven 1 time unit after the rising edge and outputs are sampled 1 unit after the edge.
// Backpressure: drn_rdy is driven directly, held low in some scenarios and randomized in others.
module tb_apb2axi_rsp_slicer;

    localparam int TAG_NUM = 8;
    localparam int DEPTH   = 8;
    localparam int AXI_W   = 64;
    localparam int APB_W   = 32;
    localparam int TAG_W   = 3;
    localparam int RATIO   = AXI_W / APB_W;

    logic               pclk;
    logic               preset;
    logic               in_vld;
    logic               in_rdy;
    logic [TAG_W-1:0]   in_tag;
    logic [AXI_W-1:0]   in_data;
    logic [1:0]         in_resp;
    logic               in_last;
    logic               drn_req;
    logic [TAG_W-1:0]   drn_tag;
    logic               drn_req_rdy;
    logic               drn_vld;
    logic               drn_rdy;
    logic [APB_W-1:0]   drn_data;
    logic               drn_last;
    logic [1:0]         drn_err;
    logic               drn_miss;
    logic               flush_vld;
    logic [TAG_W-1:0]   flush_tag;
    logic [TAG_NUM-1:0] tag_avail;
    logic [TAG_NUM-1:0] tag_err;

    int checks = 0;
    int errors = 0;

    apb2axi_rsp_slicer #(
        .TAG_NUM(TAG_NUM), .DEPTH(DEPTH), .AXI_DATA_W(AXI_W), .APB_DATA_W(APB_W)
    ) dut (
        .pclk(pclk), .preset(preset),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_tag(in_tag), .in_data(in_data),
        .in_resp(in_resp), .in_last(in_last),
        .drn_req(drn_req), .drn_tag(drn_tag), .drn_req_rdy(drn_req_rdy),
        .drn_vld(drn_vld), .drn_rdy(drn_rdy), .drn_data(drn_data),
        .drn_last(drn_last), .drn_err(drn_err), .drn_miss(drn_miss),
        .flush_vld(flush_vld), .flush_tag(flush_tag),
        .tag_avail(tag_avail), .tag_err(tag_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ------------------------------------------------------------------
    // Reference model: each tag is a queue of APB words still owed to the
    // consumer. Full beats pending = words / RATIO (a partially drained
    // beat always leaves fewer than RATIO words).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic             l;
        logic [1:0]       e;
        logic [APB_W-1:0] d;
    } word_t;

    word_t              mq [TAG_NUM][$];
    logic [TAG_NUM-1:0] merr;
    logic               mvld;
    logic               mmiss;
    word_t              mword;

    function automatic logic m_in_rdy();
        return ((mq[in_tag].size() / RATIO) < DEPTH) && !(flush_vld && (flush_tag == in_tag));
    endfunction

    function automatic logic [TAG_NUM-1:0] m_avail();
        logic [TAG_NUM-1:0] a;
        for (int t = 0; t < TAG_NUM; t++) a[t] = (mq[t].size() != 0);
        return a;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < TAG_NUM; t++) mq[t].delete();
        merr  = '0;
        mvld  = 1'b0;
        mmiss = 1'b0;
        mword = '0;
    endtask

    // Applies one clock edge worth of the rules to the model, using the
    // inputs currently driven and the pre-edge model state.
    task automatic model_step();
        logic  ia;
        logic  ra;
        word_t w;
        ia = in_vld && m_in_rdy();
        ra = drn_req && (!mvld || drn_rdy);
        if (mvld && drn_rdy) mvld = 1'b0;
        mmiss = 1'b0;
        if (ra) begin
            if (flush_vld && (flush_tag == drn_tag)) begin
                mmiss = 1'b1;
            end else if (mq[drn_tag].size() > 0) begin
                mword = mq[drn_tag].pop_front();
                mvld  = 1'b1;
            end else begin
                mmiss = 1'b1;
            end
        end
        if (flush_vld) begin
            mq[flush_tag].delete();
            merr[flush_tag] = 1'b0;
        end
        if (ia) begin
            for (int i = 0; i < RATIO; i++) begin
                w.d = in_data[i*APB_W +: APB_W];
                w.e = in_resp;
                w.l = in_last && (i == RATIO - 1);
                mq[in_tag].push_back(w);
            end
            if (in_resp[1]) merr[in_tag] = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        in_vld    = 1'b0;
        in_tag    = '0;
        in_data   = '0;
        in_resp   = '0;
        in_last   = 1'b0;
        drn_req   = 1'b0;
        drn_tag   = '0;
        drn_rdy   = 1'b1;
        flush_vld = 1'b0;
        flush_tag = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        checks++; if (drn_vld !== 1'b0) begin errors++; $display("FAIL reset_drn_vld got %b want 0", drn_vld); end
        checks++; if (drn_data !== '0) begin errors++; $display("FAIL reset_drn_data got %h want 0", drn_data); end
        checks++; if ({drn_last, drn_err, drn_miss} !== 4'b0) begin errors++; $display("FAIL reset_last_err_miss got %b want 0000", {drn_last, drn_err, drn_miss}); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        checks++; if (drn_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %b want 1", drn_req_rdy); end
        checks++; if ({tag_avail, tag_err} !== '0) begin errors++; $display("FAIL reset_status got %h/%h want 0/0", tag_avail, tag_err); end
    endtask

    task automatic test_slice_order();
        logic [APB_W-1:0] exp_w [4];
        exp_w = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666};
        idle();
        in_vld = 1'b1; in_tag = 3'd3; in_data = 64'h1111_2222_3333_4444; in_last = 1'b0;
        tick();
        in_data = 64'h5555_6666_7777_8888; in_last = 1'b1;
        tick();
        idle();
        drn_req = 1'b1; drn_tag = 3'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (drn_vld !== 1'b1 || drn_data !== exp_w[i]) begin errors++; $display("FAIL slice_word%0d got vld=%b %h want vld=1 %h", i, drn_vld, drn_data, exp_w[i]); end
            checks++; if (drn_last !== (i == 3)) begin errors++; $display("FAIL slice_last%0d got %b want %b", i, drn_last, (i == 3)); end
        end
        idle();
        tick();
        checks++; if (drn_vld !== 1'b0 || tag_avail[3] !== 1'b0) begin errors++; $display("FAIL slice_done got vld=%b avail=%b want 0/0", drn_vld, tag_avail[3]); end
    endtask

    task automatic test_full_wrap();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            in_vld = 1'b1; in_tag = 3'd0; in_data = {$urandom, $urandom}; in_last = $urandom_range(1);
            tick();
        end
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_tag0_in_rdy got %b want 0", in_rdy); end
        in_tag = 3'd1; #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL full_tag1_in_rdy got %b want 1", in_rdy); end
        // Full FIFO with a same-cycle pop still refuses the beat.
        in_tag = 3'd0; drn_req = 1'b1; drn_tag = 3'd0; #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_pop_in_rdy got %b want 0", in_rdy); end
        tick();
        in_vld = 1'b0;
        tick();
        checks++; if (drn_data !== mword.d) begin errors++; $display("FAIL full_word1 got %h want %h", drn_data, mword.d); end
        drn_req = 1'b0; in_vld = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b1; #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL after_drain_in_rdy got %b want 1", in_rdy); end
        tick();
        idle();
        drn_req = 1'b1; drn_tag = 3'd0;
        for (int i = 0; i < DEPTH * RATIO; i++) begin
            tick();
            checks++; if (drn_vld !== 1'b1 || drn_data !== mword.d || drn_last !== mword.l) begin errors++; $display("FAIL wrap_word%0d got %b %h %b want 1 %h %b", i, drn_vld, drn_data, drn_last, mword.d, mword.l); end
        end
        tick();
        checks++; if (drn_miss !== 1'b1) begin errors++; $display("FAIL wrap_end_miss got %b want 1", drn_miss); end
        idle();
        tick();
    endtask

    task automatic test_miss();
        idle();
        drn_req = 1'b1; drn_tag = 3'd5;
        tick();
        drn_req = 1'b0;
        checks++; if (drn_miss !== 1'b1 || drn_vld !== 1'b0) begin errors++; $display("FAIL miss_pulse got miss=%b vld=%b want 1/0", drn_miss, drn_vld); end
        tick();
        checks++; if (drn_miss !== 1'b0) begin errors++; $display("FAIL miss_one_cycle got %b want 0", drn_miss); end
        in_vld = 1'b1; in_tag = 3'd5; in_data = {$urandom, $urandom};
        tick();
        // Flush, request and enqueue all on tag 5 in the same cycle.
        flush_vld = 1'b1; flush_tag = 3'd5; drn_req = 1'b1; drn_tag = 3'd5; #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL flush_enq_in_rdy got %b want 0", in_rdy); end
        tick();
        idle();
        checks++; if (drn_miss !== 1'b1 || drn_vld !== 1'b0 || tag_avail[5] !== 1'b0) begin errors++; $display("FAIL flush_req got miss=%b vld=%b avail=%b want 1/0/0", drn_miss, drn_vld, tag_avail[5]); end
        tick();
    endtask

    task automatic test_err_flush();
        idle();
        in_vld = 1'b1; in_tag = 3'd2; in_data = {$urandom, $urandom}; in_resp = 2'b10;
        tick();
        idle();
        checks++; if (tag_err[2] !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", tag_err[2]); end
        drn_req = 1'b1; drn_tag = 3'd2;
        for (int i = 0; i < RATIO; i++) begin
            tick();
            checks++; if (drn_err !== 2'b10) begin errors++; $display("FAIL err_word%0d got %b want 10", i, drn_err); end
        end
        idle();
        in_vld = 1'b1; in_tag = 3'd2; in_data = {$urandom, $urandom}; in_resp = 2'b00;
        tick();
        idle();
        checks++; if (tag_err[2] !== 1'b1 || tag_avail[2] !== 1'b1) begin errors++; $display("FAIL err_hold got err=%b avail=%b want 1/1", tag_err[2], tag_avail[2]); end
        flush_vld = 1'b1; flush_tag = 3'd2;
        tick();
        idle();
        checks++; if (tag_err[2] !== 1'b0 || tag_avail[2] !== 1'b0) begin errors++; $display("FAIL err_flush got err=%b avail=%b want 0/0", tag_err[2], tag_avail[2]); end
    endtask

    task automatic test_backpressure();
        logic [APB_W-1:0] held;
        idle();
        in_vld = 1'b1; in_tag = 3'd6;
        for (int i = 0; i < 2; i++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        idle();
        drn_req = 1'b1; drn_tag = 3'd6; drn_rdy = 1'b0;
        tick();
        held = drn_data;
        checks++; if (drn_vld !== 1'b1 || drn_data !== mword.d) begin errors++; $display("FAIL bp_first got %b %h want 1 %h", drn_vld, drn_data, mword.d); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (drn_req_rdy !== 1'b0) begin errors++; $display("FAIL bp_req_rdy%0d got %b want 0", i, drn_req_rdy); end
            tick();
            checks++; if (drn_vld !== 1'b1 || drn_data !== held) begin errors++; $display("FAIL bp_stable%0d got %b %h want 1 %h", i, drn_vld, drn_data, held); end
        end
        drn_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (drn_vld !== 1'b1 || drn_data !== mword.d) begin errors++; $display("FAIL bp_release%0d got %b %h want 1 %h", i, drn_vld, drn_data, mword.d); end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        int pv;
        for (int c = 0; c < 600; c++) begin
            pv = (c < 300) ? 50 : 15;
            in_vld    = ($urandom_range(99) < pv);
            in_tag    = TAG_W'($urandom_range(3));
            in_data   = {$urandom, $urandom};
            in_resp   = 2'($urandom_range(3));
            in_last   = $urandom_range(1);
            drn_req   = ($urandom_range(99) < 55);
            drn_tag   = TAG_W'($urandom_range(3));
            drn_rdy   = ($urandom_range(99) < 75);
            flush_vld = ($urandom_range(99) < 3);
            flush_tag = TAG_W'($urandom_range(3));
            #1;
            checks++; if (in_rdy !== m_in_rdy()) begin errors++; $display("FAIL rnd_in_rdy c%0d got %b want %b", c, in_rdy, m_in_rdy()); end
            checks++; if (drn_req_rdy !== (!mvld || drn_rdy)) begin errors++; $display("FAIL rnd_req_rdy c%0d got %b want %b", c, drn_req_rdy, (!mvld || drn_rdy)); end
            checks++; if (tag_avail !== m_avail() || tag_err !== merr) begin errors++; $display("FAIL rnd_status c%0d got %h/%h want %h/%h", c, tag_avail, tag_err, m_avail(), merr); end
            tick();
            checks++; if (drn_vld !== mvld || drn_miss !== mmiss) begin errors++; $display("FAIL rnd_vld_miss c%0d got %b/%b want %b/%b", c, drn_vld, drn_miss, mvld, mmiss); end
            if (mvld) begin
                checks++; if ({drn_last, drn_err, drn_data} !== {mword.l, mword.e, mword.d}) begin errors++; $display("FAIL rnd_word c%0d got %b %b %h want %b %b %h", c, drn_last, drn_err, drn_data, mword.l, mword.e, mword.d); end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_slice();
        idle();
        in_vld = 1'b1; in_tag = 3'd4; in_data = {$urandom, $urandom};
        tick();
        idle();
        drn_req = 1'b1; drn_tag = 3'd4; drn_rdy = 1'b0;
        tick();
        checks++; if (drn_vld !== 1'b1 || tag_avail[4] !== 1'b1) begin errors++; $display("FAIL mid_pre got vld=%b avail=%b want 1/1", drn_vld, tag_avail[4]); end
        idle();
        #2 preset = 1'b1;
        #1;
        checks++; if (drn_vld !== 1'b0 || tag_avail !== '0) begin errors++; $display("FAIL mid_async got vld=%b avail=%h want 0/00", drn_vld, tag_avail); end
        #2 preset = 1'b0;
        model_reset();
        tick();
        checks++; if (drn_vld !== 1'b0 || tag_avail !== '0 || in_rdy !== 1'b1) begin errors++; $display("FAIL mid_after got vld=%b avail=%h in_rdy=%b want 0/00/1", drn_vld, tag_avail, in_rdy); end
    endtask

    initial begin
        idle();
        model_reset();
        preset = 1'b1;
        #3;
        test_reset();
        #9 preset = 1'b0;
        tick();
        test_slice_order();
        test_full_wrap();
        test_miss();
        test_err_flush();
        test_backpressure();
        test_random();
        test_reset_mid_slice();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
